// File: rtl/nibble_adder_pkg.sv
// Shared constants and types for the nibble-serial adder.
//   NIBBLE_W  : width of one adder slice
//   state_t   : control FSM encoding
//   idx_width : bit width needed to count the nibbles of one operation
package nibble_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A single-nibble operation still needs a 1-bit counter.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_rca.sv
// 4-bit ripple-carry adder slice.
//   a, b : 4-bit addends
//   cin  : carry in
//   sum  : 5-bit result, carry-out in bit 4
module nibble_serial_adder_rca (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [4:0] sum
);

  // Separate carry nets keep the ripple chain free of vector self-dependency.
  logic c1, c2, c3, c4;

  assign sum[0] = a[0] ^ b[0] ^ cin;
  assign c1     = (a[0] & b[0]) | (a[0] & cin) | (b[0] & cin);
  assign sum[1] = a[1] ^ b[1] ^ c1;
  assign c2     = (a[1] & b[1]) | (a[1] & c1) | (b[1] & c1);
  assign sum[2] = a[2] ^ b[2] ^ c2;
  assign c3     = (a[2] & b[2]) | (a[2] & c2) | (b[2] & c2);
  assign sum[3] = a[3] ^ b[3] ^ c3;
  assign c4     = (a[3] & b[3]) | (a[3] & c3) | (b[3] & c3);
  assign sum[4] = c4;

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder that reuses one 4-bit ripple-carry slice,
// processing one nibble per clock, least-significant first.
//   clk, rst_n : clock and asynchronous active-low reset
//   start      : request, accepted when not busy
//   a, b, cin  : operands and carry-in, captured with start
//   busy       : nibbles in flight
//   done       : one-cycle completion pulse
//   sum, cout  : result, held until the next completion
module nibble_serial_adder
  import nibble_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = idx_width(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  if (WIDTH < NIBBLE_W || (WIDTH % NIBBLE_W) != 0) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a non-zero multiple of 4");
  end

  state_t                      state;
  logic [WIDTH-1:0]            a_sh;
  logic [WIDTH-1:0]            b_sh;
  logic [WIDTH-1:0]            res_sh;
  logic                        carry_q;
  logic [IDX_W-1:0]            idx;
  logic [NIBBLE_W:0]           slice_sum;
  logic [WIDTH+NIBBLE_W-1:0]   res_cat;

  nibble_serial_adder_rca u_slice (
    .a   (a_sh[NIBBLE_W-1:0]),
    .b   (b_sh[NIBBLE_W-1:0]),
    .cin (carry_q),
    .sum (slice_sum)
  );

  // New nibble enters at the top; after NIBBLES shifts the word is aligned.
  assign res_cat = {slice_sum[NIBBLE_W-1:0], res_sh};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      res_sh  <= '0;
      carry_q <= 1'b0;
      idx     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sh    <= a;
            b_sh    <= b;
            carry_q <= cin;
            idx     <= '0;
            state   <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          res_sh  <= res_cat[WIDTH+NIBBLE_W-1:NIBBLE_W];
          carry_q <= slice_sum[NIBBLE_W];
          a_sh    <= a_sh >> NIBBLE_W;
          b_sh    <= b_sh >> NIBBLE_W;
          idx     <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            sum   <= res_cat[WIDTH+NIBBLE_W-1:NIBBLE_W];
            cout  <= slice_sum[NIBBLE_W];
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;

  localparam int W = 16;
  localparam int N = W / 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int n_checks = 0;
  int n_pass   = 0;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: a request taken while idle yields a+b+cin exactly
  // N edges later, shown for one cycle; the result holds afterwards.
  int         m_left;
  bit         m_busy;
  bit         m_done;
  logic [W:0] m_pend;
  logic [W:0] m_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0;
      m_busy = 0;
      m_done = 0;
      m_pend = '0;
      m_res  = '0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0;
          m_done = 1;
          m_res  = m_pend;
        end
      end else if (start) begin
        m_pend = {1'b0, a} + {1'b0, b} + (W + 1)'(cin);
        m_left = N;
        m_busy = 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc_busy", 32'(busy), 32'(m_busy));
    chk("cyc_done", 32'(done), 32'(m_done));
    chk("cyc_sum",  32'(sum),  32'(m_res[W-1:0]));
    chk("cyc_cout", 32'(cout), 32'(m_res[W]));
  end

  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc);
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the negedge after the accepting edge; returns edges until done.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                    input logic tc, input logic [W-1:0] es, input logic ec);
    int lat;
    issue(ta, tb_v, tc);
    chk({nm, "_busy"}, 32'(busy), 32'd1);
    wait_done(lat);
    chk({nm, "_latency"}, 32'(lat), 32'(N));
    chk({nm, "_sum"}, 32'(sum), 32'(es));
    chk({nm, "_cout"}, 32'(cout), 32'(ec));
    @(negedge clk);
    chk({nm, "_done_drop"}, 32'(done), 32'd0);
    chk({nm, "_sum_hold"}, 32'(sum), 32'(es));
  endtask

  initial begin
    int lat;
    int dcount;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum",  32'(sum),  32'd0);
    rst_n = 1'b1;

    op("basic",  16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
    op("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    op("allone", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);

    // start during RUN must be ignored
    issue(16'h00F0, 16'h0010, 1'b0);
    @(negedge clk);
    a = 16'h1111; b = 16'h1111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dcount = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) begin
        dcount++;
        chk("ignore_sum", 32'(sum), 32'h0100);
        chk("ignore_cout", 32'(cout), 32'd0);
      end
      @(negedge clk);
    end
    chk("ignore_done_count", 32'(dcount), 32'd1);

    // asynchronous reset mid-operation
    issue(16'h8000, 16'h8000, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_sum",  32'(sum),  32'd0);
    chk("arst_cout", 32'(cout), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("arst_no_done", 32'(dcount), 32'd0);
    op("post_rst", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0);

    // back-to-back: restart during the done cycle
    issue(16'h000F, 16'h0001, 1'b0);
    wait_done(lat);
    chk("b2b_first_sum", 32'(sum), 32'h0010);
    a = 16'h7FFF; b = 16'h0001; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_hold", 32'(sum), 32'h0010);
    wait_done(lat);
    chk("b2b_latency", 32'(lat), 32'(N));
    chk("b2b_sum", 32'(sum), 32'h8000);
    chk("b2b_cout", 32'(cout), 32'd0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
